// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked inter-stage pipeline registers.
// Holds the stage state encoding (doubling as the occupancy count), the
// bubble control value, per-boundary default field widths and a helper
// that maps a stage state to its entry count.
package pipe_pkg;

    // Encoding equals the number of held entries: EMPTY=0, BUSY=1, FULL=2.
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_BUSY  = 2'd1,
        STAGE_FULL  = 2'd2
    } stage_state_e;

    // Widest control field any stage may use; the bubble is sliced from this.
    localparam int CTRL_MAX_W = 64;
    localparam logic [CTRL_MAX_W-1:0] CTRL_BUBBLE = 64'd0;

    // Default field widths per pipeline boundary.
    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 9;
    localparam int ID_EX_DATA_W  = 89;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 70;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    // Number of entries held in a given stage state.
    function automatic logic [1:0] state_occupancy(input stage_state_e s);
        logic [1:0] occ;
        case (s)
            STAGE_EMPTY: occ = 2'd0;
            STAGE_BUSY:  occ = 2'd1;
            STAGE_FULL:  occ = 2'd2;
            default:     occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - clock, rising edge
//   clear  - synchronous clear to zero (highest priority)
//   inc    - increment request; ignored once the counter is at all-ones
//   count  - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: hold at the maximum instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register between CPU stages with optional two-entry
// skid buffer, bubble-inserting flush and a saturating back-pressure counter.
// Ports:
//   CLK, Reset          - clock and synchronous active-high reset
//   flush               - drop all held entries; next cycle is a bubble
//   in_valid/in_ready   - upstream handshake; in_ctrl/in_data payload
//   out_valid/out_ready - downstream handshake; out_ctrl/out_data payload
//   out_ctrl            - zero whenever out_valid is low (a NOP downstream)
//   out_data            - keeps its last value while invalid
//   stall_cnt           - cycles with out_valid & !out_ready, saturating
//   occupancy           - number of held entries (0..2)
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 89,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    localparam logic [CTRL_W-1:0] BUBBLE    = CTRL_BUBBLE[CTRL_W-1:0];
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occupancy_q, occupancy_d;
    logic              in_fire_s;
    logic              out_fire_s;

    // With the skid buffer the ready path comes straight from a flop; without
    // it, a full stage may still accept when downstream drains this cycle.
    assign in_ready   = ~Reset & ((SKID != 32'sd0) ? in_ready_q : (~out_valid_q | out_ready));
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_q & out_ready;

    // Next-state and storage update; main_ctrl is forced to the bubble value
    // whenever the stage goes empty so out_ctrl needs no output gating.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = STAGE_EMPTY;
            main_ctrl_d = BUBBLE;
            skid_ctrl_d = BUBBLE;
            skid_data_d = DATA_ZERO;
        end else begin
            case (state_q)
                STAGE_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = STAGE_BUSY;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else begin
                        state_d = STAGE_EMPTY;
                    end
                end
                STAGE_BUSY: begin
                    if (in_fire_s && (out_fire_s || (SKID == 32'sd0))) begin
                        state_d     = STAGE_BUSY;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire_s) begin
                        state_d     = STAGE_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire_s) begin
                        state_d     = STAGE_EMPTY;
                        main_ctrl_d = BUBBLE;
                    end else begin
                        state_d = STAGE_BUSY;
                    end
                end
                STAGE_FULL: begin
                    if (out_fire_s) begin
                        state_d     = STAGE_BUSY;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = BUBBLE;
                        skid_data_d = DATA_ZERO;
                    end else begin
                        state_d = STAGE_FULL;
                    end
                end
                default: begin
                    state_d     = STAGE_EMPTY;
                    main_ctrl_d = BUBBLE;
                end
            endcase
        end
        in_ready_d  = (state_d != STAGE_FULL);
        out_valid_d = (state_d != STAGE_EMPTY);
        occupancy_d = state_occupancy(state_d);
    end

    // Stage state and storage registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= STAGE_EMPTY;
            main_ctrl_q <= BUBBLE;
            main_data_q <= DATA_ZERO;
            skid_ctrl_q <= BUBBLE;
            skid_data_q <= DATA_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .clear (Reset),
        .inc   (out_valid_q & ~out_ready),
        .count (stall_cnt)
    );

    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // ---------------- DUT a: SKID=1, default widths ----------------
    logic        a_rst, a_fl, a_iv, a_ir, a_ov, a_ordy;
    logic [8:0]  a_ictrl, a_octrl;
    logic [88:0] a_idata, a_odata;
    logic [15:0] a_stall;
    logic [1:0]  a_occ;

    pipe_stage_hs #(.CTRL_W(9), .DATA_W(89), .SKID(1), .CNT_W(16)) dut_a (
        .CLK(clk), .Reset(a_rst), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir),
        .in_ctrl(a_ictrl), .in_data(a_idata), .out_valid(a_ov), .out_ready(a_ordy),
        .out_ctrl(a_octrl), .out_data(a_odata), .stall_cnt(a_stall), .occupancy(a_occ)
    );

    // ---------------- DUT b: SKID=0 ----------------
    logic        b_rst, b_fl, b_iv, b_ir, b_ov, b_ordy;
    logic [8:0]  b_ictrl, b_octrl;
    logic [31:0] b_idata, b_odata;
    logic [15:0] b_stall;
    logic [1:0]  b_occ;

    pipe_stage_hs #(.CTRL_W(9), .DATA_W(32), .SKID(0), .CNT_W(16)) dut_b (
        .CLK(clk), .Reset(b_rst), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir),
        .in_ctrl(b_ictrl), .in_data(b_idata), .out_valid(b_ov), .out_ready(b_ordy),
        .out_ctrl(b_octrl), .out_data(b_odata), .stall_cnt(b_stall), .occupancy(b_occ)
    );

    // ---------------- DUT c: SKID=1, CNT_W=4 ----------------
    logic        c_rst, c_fl, c_iv, c_ir, c_ov, c_ordy;
    logic [8:0]  c_ictrl, c_octrl;
    logic [7:0]  c_idata, c_odata;
    logic [3:0]  c_stall;
    logic [1:0]  c_occ;

    pipe_stage_hs #(.CTRL_W(9), .DATA_W(8), .SKID(1), .CNT_W(4)) dut_c (
        .CLK(clk), .Reset(c_rst), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir),
        .in_ctrl(c_ictrl), .in_data(c_idata), .out_valid(c_ov), .out_ready(c_ordy),
        .out_ctrl(c_octrl), .out_data(c_odata), .stall_cnt(c_stall), .occupancy(c_occ)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One directed cycle: inputs driven for the cycle, outputs expected during it.
    typedef struct {
        logic        rst, fl, iv;
        logic [8:0]  ictrl;
        logic [88:0] idata;
        logic        ordy;
        logic        e_ir, e_ov;
        logic [8:0]  e_octrl;
        logic [88:0] e_odata;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [8:0] ictrl, input logic [15:0] idata, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [8:0] e_octrl,
                                input logic [15:0] e_odata, input logic [1:0] e_occ, input logic [15:0] e_stall);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ictrl = ictrl; v.idata = 89'(idata); v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_octrl = e_octrl; v.e_odata = 89'(e_odata);
        v.e_occ = e_occ; v.e_stall = e_stall;
        return v;
    endfunction

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] data;
    } ent_t;

    vec_t vecs[17];
    ent_t q[$];

    initial begin
        //                rst  fl   iv   ictrl    idata      ordy | ir  ov   octrl    odata      occ   stall
        vecs[0]  = mk(1'b1,1'b0,1'b1,9'h1A5,16'h0111,1'b0, 1'b0,1'b0,9'h000,16'h0000,2'd0,16'd0);
        vecs[1]  = mk(1'b1,1'b0,1'b1,9'h1A5,16'h0111,1'b0, 1'b0,1'b0,9'h000,16'h0000,2'd0,16'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b1,9'h1A5,16'h0111,1'b0, 1'b1,1'b0,9'h000,16'h0000,2'd0,16'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b1,9'h0F3,16'h0222,1'b0, 1'b1,1'b1,9'h1A5,16'h0111,2'd1,16'd0);
        vecs[4]  = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b0, 1'b0,1'b1,9'h1A5,16'h0111,2'd2,16'd1);
        vecs[5]  = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b0,1'b1,9'h1A5,16'h0111,2'd2,16'd2);
        vecs[6]  = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b1,1'b1,9'h0F3,16'h0222,2'd1,16'd2);
        vecs[7]  = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b1,1'b0,9'h000,16'h0222,2'd0,16'd2);
        vecs[8]  = mk(1'b0,1'b0,1'b1,9'h011,16'h0333,1'b0, 1'b1,1'b0,9'h000,16'h0222,2'd0,16'd2);
        vecs[9]  = mk(1'b0,1'b0,1'b1,9'h022,16'h0444,1'b0, 1'b1,1'b1,9'h011,16'h0333,2'd1,16'd2);
        vecs[10] = mk(1'b0,1'b1,1'b1,9'h155,16'h0555,1'b0, 1'b0,1'b1,9'h011,16'h0333,2'd2,16'd3);
        vecs[11] = mk(1'b0,1'b0,1'b0,9'h155,16'h0555,1'b1, 1'b1,1'b0,9'h000,16'h0333,2'd0,16'd4);
        vecs[12] = mk(1'b0,1'b0,1'b1,9'h0AA,16'h0666,1'b1, 1'b1,1'b0,9'h000,16'h0333,2'd0,16'd4);
        vecs[13] = mk(1'b0,1'b1,1'b1,9'h0BB,16'h0777,1'b1, 1'b1,1'b1,9'h0AA,16'h0666,2'd1,16'd4);
        vecs[14] = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b1,1'b0,9'h000,16'h0666,2'd0,16'd4);
        vecs[15] = mk(1'b1,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b0,1'b0,9'h000,16'h0666,2'd0,16'd4);
        vecs[16] = mk(1'b0,1'b0,1'b0,9'h000,16'h0000,1'b1, 1'b1,1'b0,9'h000,16'h0000,2'd0,16'd0);

        a_rst = 1'b1; a_fl = 1'b0; a_iv = 1'b0; a_ictrl = 9'h000; a_idata = 89'd0; a_ordy = 1'b0;
        b_rst = 1'b1; b_fl = 1'b0; b_iv = 1'b0; b_ictrl = 9'h000; b_idata = 32'd0; b_ordy = 1'b0;
        c_rst = 1'b1; c_fl = 1'b0; c_iv = 1'b0; c_ictrl = 9'h000; c_idata = 8'd0;  c_ordy = 1'b0;
        @(posedge clk);

        // Reset, skid fill/drain, flush while FULL, flush with concurrent in/out fire.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_rst = vecs[i].rst; a_fl = vecs[i].fl; a_iv = vecs[i].iv;
            a_ictrl = vecs[i].ictrl; a_idata = vecs[i].idata; a_ordy = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i),  128'(a_ir),    128'(vecs[i].e_ir));
            check($sformatf("v%0d out_valid", i), 128'(a_ov),    128'(vecs[i].e_ov));
            check($sformatf("v%0d out_ctrl", i),  128'(a_octrl), 128'(vecs[i].e_octrl));
            check($sformatf("v%0d out_data", i),  128'(a_odata), 128'(vecs[i].e_odata));
            check($sformatf("v%0d occupancy", i), 128'(a_occ),   128'(vecs[i].e_occ));
            check($sformatf("v%0d stall_cnt", i), 128'(a_stall), 128'(vecs[i].e_stall));
        end

        // Streaming: 8 entries back to back, one-cycle latency, no stalls.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_rst = 1'b0; a_fl = 1'b0; a_iv = (k < 8); a_ordy = 1'b1;
            a_ictrl = 9'(k); a_idata = 89'(k * 3);
            #1;
            check($sformatf("stream%0d in_ready", k), 128'(a_ir), 128'(1));
            if (k >= 1 && k <= 8) begin
                check($sformatf("stream%0d out_valid", k), 128'(a_ov),    128'(1));
                check($sformatf("stream%0d out_ctrl", k),  128'(a_octrl), 128'(k - 1));
                check($sformatf("stream%0d out_data", k),  128'(a_odata), 128'((k - 1) * 3));
                check($sformatf("stream%0d occupancy", k), 128'(a_occ),   128'(1));
            end else begin
                check($sformatf("stream%0d out_valid", k), 128'(a_ov), 128'(0));
            end
        end
        check("stream stall_cnt", 128'(a_stall), 128'(0));

        // Saturating stall counter with CNT_W=4.
        @(negedge clk);
        c_rst = 1'b0; c_iv = 1'b1; c_ictrl = 9'h007; c_idata = 8'h5A; c_ordy = 1'b0;
        @(negedge clk);
        c_iv = 1'b0;
        #1;
        check("sat out_ctrl",  128'(c_octrl), 128'(9'h007));
        check("sat out_data",  128'(c_odata), 128'(8'h5A));
        check("sat occupancy", 128'(c_occ),   128'(1));
        check("sat in_ready",  128'(c_ir),    128'(1));
        for (int n = 0; n <= 20; n++) begin
            check($sformatf("sat stall n=%0d", n), 128'(c_stall), 128'((n > 15) ? 15 : n));
            @(negedge clk);
            #1;
        end
        check("sat out_valid held", 128'(c_ov), 128'(1));
        c_rst = 1'b1;
        @(negedge clk);
        #1;
        check("sat stall after reset", 128'(c_stall), 128'(0));
        check("sat out_valid after reset", 128'(c_ov), 128'(0));
        c_rst = 1'b0;

        // SKID=0 random traffic against a queue model.
        begin
            logic        exp_ov, exp_ir;
            logic [8:0]  exp_ctrl;
            logic [31:0] exp_data;
            logic [31:0] last_data;
            logic [1:0]  exp_occ;
            int          model_stall;
            bit          ok;
            last_data   = 32'd0;
            model_stall = 0;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                @(negedge clk);
                b_rst   = 1'b0;
                b_iv    = (($urandom % 4) != 0);
                b_ordy  = (($urandom % 3) != 0);
                b_fl    = (($urandom % 40) == 0);
                b_ictrl = 9'($urandom);
                b_idata = $urandom;
                #1;
                exp_ov   = (q.size() != 0);
                exp_ir   = !exp_ov || b_ordy;
                exp_occ  = 2'(q.size());
                exp_ctrl = exp_ov ? q[0].ctrl : 9'h000;
                exp_data = exp_ov ? q[0].data : last_data;
                ok = (b_ov === exp_ov) && (b_ir === exp_ir) && (b_occ === exp_occ) &&
                     (b_octrl === exp_ctrl) && (b_odata === exp_data);
                n_chk++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL rand_skid0 cyc %0d: got ov=%0b ir=%0b occ=%0d ctrl=%0h data=%0h, expected ov=%0b ir=%0b occ=%0d ctrl=%0h data=%0h",
                             cyc, b_ov, b_ir, b_occ, b_octrl, b_odata, exp_ov, exp_ir, exp_occ, exp_ctrl, exp_data);
                end
                if (exp_ov && !b_ordy) begin
                    model_stall++;
                end
                if (exp_ov && b_ordy) begin
                    void'(q.pop_front());
                end
                if (b_fl) begin
                    q.delete();
                end else if (b_iv && exp_ir) begin
                    q.push_back('{ctrl: b_ictrl, data: b_idata});
                    last_data = b_idata;
                end
            end
            @(negedge clk);
            b_iv = 1'b0; b_fl = 1'b0;
            #1;
            check("rand stall_cnt", 128'(b_stall), 128'(model_stall));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
Parametrised successor to the fixed-field pipeline registers between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generic payload split into a control field and a data field.
- Replaces the single write-enable with a valid/ready handshake and an optional two-entry skid buffer, so ready paths are registered.
- Adds a flush that inserts a bubble, and a saturating back-pressure counter for profiling.

Parameters:
CTRL_W, 9, width of control field (RegWrite/ALUSrc/ALUOP/MemWrite/MemRead/RegStore-class bits); zeroed on bubble
DATA_W, 89, width of data field (PC, operands, immediate, register indices); held on bubble
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall counter

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries; next cycle is a bubble
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  out_ctrl/out_data hold a valid entry
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0
out_data  out  DATA_W  data field; holds last value when invalid
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on port Reset.
- Reset values, sampled at an edge with Reset=1:
  - out_valid=0, out_ctrl=0, out_data=0.
  - Skid entry cleared; stall_cnt=0; occupancy=0.
  - in_ready=0 combinationally while Reset=1; in_ready=1 on the first cycle after reset.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- SKID=1 state machine; occupancy is 0/1/2 for EMPTY/BUSY/FULL:
  - EMPTY:
    - in_fire -> BUSY, main<=in.
  - BUSY:
    - in_fire & out_fire -> BUSY, main<=in.
    - in_fire & !out_fire -> FULL, skid<=in.
    - !in_fire & out_fire -> EMPTY.
  - FULL:
    - in_ready=0.
    - out_fire -> BUSY, main<=skid.
  - in_ready = !Reset & (state!=FULL), driven from a register.
- SKID=0:
  - in_ready = !Reset & (!out_valid | out_ready).
  - in_fire loads main; out_fire without in_fire -> EMPTY.
- Ordering: strictly FIFO. Entries are never duplicated or reordered.
- out_ctrl = main_ctrl when out_valid, else 0. This is a bubble, i.e. a NOP to downstream decode.
- flush:
  - Takes effect at the edge where sampled.
  - Next state is EMPTY and the skid entry is cleared.
  - An input fired in the same cycle is dropped.
  - An out_fire in the flush cycle still completes downstream.
  - stall_cnt is unaffected.
- Priority: Reset > flush > transfers.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by Reset.
- out_data: unchanged on bubble/flush, which saves toggle power. Consumers must qualify it with out_valid.
- Input stability: in_valid=1 with in_ready=0 requires the upstream to hold its payload. The stage never samples in that cycle.

Decomposition:
- Shared package pipe_pkg:
  - STAGE_EMPTY / STAGE_BUSY / STAGE_FULL state encodings.
  - CTRL_BUBBLE constant (all-zero).
  - Default CTRL_W/DATA_W per stage boundary (IF_ID, ID_EX, EX_MEM, MEM_WB).
- One natural sub-module: sat_counter (CNT_W, inc, clear → count), used for stall_cnt.
- The skid/main storage stays inline.

Test Plan:
1. Reset=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ctrl=0, occupancy=0. Cycle after release: in_ready=1.
2. SKID=1; push 0x1A5, 0x0F3 with out_ready=0 -> occupancy 1 then 2, in_ready=0 at 2, stall_cnt=1 then 2. Set out_ready=1 -> out_ctrl 0x1A5 then 0x0F3, then out_valid=0.
3. Streaming, in_valid=out_ready=1 for 8 entries 0..7 -> outputs 0..7 on consecutive cycles starting 1 cycle later, in_ready constantly 1, occupancy constantly 1.
4. FULL, flush=1 with in_valid=1 (ctrl 0x155) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0x155 never emitted, out_data unchanged.
5. CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15. Reset -> 0.
6. SKID=0, random valid/ready for 1000 cycles vs scoreboard -> exact in-order match, no loss, no duplication, in_ready == !out_valid | out_ready.
